ramctrl: RTL
============

RAMCTRL -- requirements
Module: ramctrl

Interface
REQ-001 SHALL have `clk_in`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `rst_in`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have `rdy_in`, input, 1 bit: global enable; while low, all state SHALL freeze.
REQ-004 SHALL have `icache_ramctrl_en_in`, input, 1: i-cache fetch request, held until served.
REQ-005 SHALL have `icache_ramctrl_addr_in`, input, `AddressWidth: byte address of the 4-byte fetch.
REQ-006 SHALL have `ramctrl_icache_inst_rdy_out`, output, 1: fetch-done pulse. `ramctrl_icache_inst_inst_out`, output, `IDWidth: fetched word.
REQ-007 SHALL have `lsb_ramctrl_en_in`, input, 1: data request, held until served. `lsb_ramctrl_rw_in`, input, 1: 1 means write.
REQ-008 SHALL have `lsb_ramctrl_addr_in`, input, `AddressWidth: address. `lsb_ramctrl_len_in`, input, 2: encoding 0/1/2 means 1/2/4 bytes; 3 is treated as 4.
REQ-009 SHALL have `lsb_ramctrl_data_in`, input, 32: store data. `ramctrl_lsb_rdy_out`, output, 1: done pulse. `ramctrl_lsb_data_out`, output, 32: load data.
REQ-010 SHALL have `mem_din_in`, input, 8; `mem_dout_out`, output, 8; `mem_a_out`, output, 32; `mem_wr_out`, output, 1 (1 means write); `io_buffer_full_in`, input, 1.

Function
REQ-011 SHALL use the states IDLE, READ, WRITE and DONE.
REQ-012 In IDLE, SHALL accept at most one request per edge; if both are pending, the LSB request SHALL win. The loser stays pending; in-flight transfers are never preempted.
REQ-013 On accepting a request at edge t, SHALL latch address, length, direction, data and requester. An i-cache request is always a 4-byte read.
REQ-014 READ of N bytes: during cycles t+1..t+N, `mem_a_out` SHALL equal addr+k (k=0..N-1). Byte k arrives on `mem_din_in` one cycle later and SHALL be stored at bits [8k+7:8k] (little-endian). Unused upper bytes SHALL be zero.
REQ-015 READ SHALL enter DONE after the last byte is captured; the requester's rdy SHALL be high only in cycle t+N+2, with data valid in that cycle. A 4-byte fetch completes 6 cycles after acceptance.
REQ-016 WRITE of N bytes: during cycles t+1..t+N, `mem_wr_out` SHALL be 1, `mem_a_out` SHALL be addr+k and `mem_dout_out` SHALL be data[8k+7:8k]. `ramctrl_lsb_rdy_out` SHALL be high only in cycle t+N+1.
REQ-017 DONE SHALL last exactly one cycle, and no request SHALL be accepted in it, so a requester dropping en on seeing rdy is never served twice. DONE SHALL then return to IDLE.
REQ-018 Outside active transfer cycles, `mem_wr_out` SHALL be 0 and `mem_a_out` SHALL be 0.
REQ-019 Address increments SHALL wrap modulo 2^32.
REQ-020 When `rdy_in` is low, counters, state and outputs SHALL hold, and `mem_wr_out` SHALL be forced to 0 combinationally. A write resumes at the same byte with no duplicate or skipped bytes.
REQ-021 Done pulses SHALL be exactly one enabled cycle wide and SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-022 While `rst_in` is high at an edge: state SHALL become IDLE, all rdy outputs SHALL be 0, both data outputs SHALL be 0, `mem_wr_out` SHALL be 0, `mem_a_out` SHALL be 0, and counters SHALL be 0.
REQ-023 Reset mid-transfer SHALL abort the transfer with no rdy pulse. Reset SHALL take priority over `rdy_in`.

Configuration
REQ-024 Macro `RAMCTRL_IO_STALL_EN`, when defined: an LSB write with addr[17:16]==2'b11 SHALL NOT be accepted while `io_buffer_full_in` is high. It stays pending; the i-cache MAY be served meanwhile.
REQ-025 With `RAMCTRL_IO_STALL_EN` undefined, `io_buffer_full_in` SHALL be ignored.

Structure
REQ-026 `AddressWidth`, `IDWidth` and the length encodings SHALL live in the shared constant.vh. State encodings SHALL be local parameters.
REQ-027 The block SHALL be a single module with no sub-module.

Verification
REQ-028 Fetch: i-cache en with addr 0x1000, RAM bytes 13,05,00,00 -> `mem_a_out` 0x1000..0x1003; inst_rdy in one cycle, 6 cycles after accept, with inst 0x00000513.
REQ-029 Store: LSB write, len=1, addr 0x2002, data 0xAABBCCDD -> writes CC to 0x2003 and DD to 0x2002; rdy 3 cycles after accept.
REQ-030 Conflict: both en high in the same IDLE cycle -> LSB served first; i-cache accepted in the cycle after DONE.
REQ-031 Pause: `rdy_in` low for 3 cycles mid 4-byte write -> exactly 4 RAM writes, `mem_wr_out` 0 while paused.
REQ-032 IO (macro defined): write to 0x30000 with `io_buffer_full_in`=1 for 5 cycles -> no write until full drops; then one write.
REQ-033 Reset mid-read -> no rdy pulse; next fetch correct.

Source files
------------

// File: rtl/ramctrl_pkg.sv
// ---------------------------------------------------------------------------
// ramctrl_pkg -- constants shared by the RAM controller and its users.
//   ADDRESS_WIDTH : width of byte addresses on every request port and the RAM
//   ID_WIDTH      : width of an instruction word returned to the i-cache
//   LEN_*         : LSB access-length encodings (3 is treated as a word)
//   len_to_bytes  : converts a length encoding into a byte count (1/2/4)
// ---------------------------------------------------------------------------
package ramctrl_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 32;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;  // LEN_WORD and the unused code 3
    endcase
  endfunction

endpackage

// File: rtl/ramctrl.sv
// ---------------------------------------------------------------------------
// ramctrl -- arbitrates i-cache fetches and LSB loads/stores onto a byte-wide
// synchronous RAM (one cycle read latency). The LSB wins when both requesters
// are pending; a transfer in flight is never preempted.
//
// Ports
//   clk_in, rst_in (sync, active-high), rdy_in (global enable / freeze)
//   icache_ramctrl_en_in/_addr_in        : fetch request (always 4-byte read)
//   ramctrl_icache_inst_rdy_out/_inst_out: fetch-done pulse and word
//   lsb_ramctrl_en_in/_rw_in/_addr_in/_len_in/_data_in : data request
//   ramctrl_lsb_rdy_out/_data_out        : data-done pulse and load word
//   mem_din_in, mem_dout_out, mem_a_out, mem_wr_out : RAM port
//   io_buffer_full_in                    : IO back-pressure
//
// Build option: define RAMCTRL_IO_STALL_EN to hold off LSB writes to the IO
// window (addr[17:16] == 2'b11) while io_buffer_full_in is high. Without it
// io_buffer_full_in is ignored.
// ---------------------------------------------------------------------------
module ramctrl
  import ramctrl_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     icache_ramctrl_en_in,
  input  logic [ADDRESS_WIDTH-1:0] icache_ramctrl_addr_in,
  output logic                     ramctrl_icache_inst_rdy_out,
  output logic [ID_WIDTH-1:0]      ramctrl_icache_inst_inst_out,
  input  logic                     lsb_ramctrl_en_in,
  input  logic                     lsb_ramctrl_rw_in,
  input  logic [ADDRESS_WIDTH-1:0] lsb_ramctrl_addr_in,
  input  logic [1:0]               lsb_ramctrl_len_in,
  input  logic [31:0]              lsb_ramctrl_data_in,
  output logic                     ramctrl_lsb_rdy_out,
  output logic [31:0]              ramctrl_lsb_data_out,
  input  logic [7:0]               mem_din_in,
  output logic [7:0]               mem_dout_out,
  output logic [ADDRESS_WIDTH-1:0] mem_a_out,
  output logic                     mem_wr_out,
  input  logic                     io_buffer_full_in
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [2:0]               r_nbytes;   // transfer length in bytes (1/2/4)
  logic [2:0]               r_cnt;      // enabled cycles spent in READ/WRITE
  logic                     r_is_lsb;
  logic [31:0]              r_wdata;
  logic [31:0]              r_buf;      // read bytes assembled so far

  logic                     w_lsb_go;
  logic                     w_icache_go;
  logic                     w_read_last;
  logic                     w_write_last;
  logic [2:0]               w_cap_idx;
  logic [31:0]              w_read_word;

`ifdef RAMCTRL_IO_STALL_EN
  assign w_lsb_go = lsb_ramctrl_en_in &&
                    !(lsb_ramctrl_rw_in && (lsb_ramctrl_addr_in[17:16] == 2'b11) &&
                      io_buffer_full_in);
`else
  logic w_unused_io_full;
  assign w_unused_io_full = io_buffer_full_in;
  assign w_lsb_go         = lsb_ramctrl_en_in;
`endif
  assign w_icache_go = icache_ramctrl_en_in && !w_lsb_go;

  // RAM data lags the address by one cycle, so in READ cycle r_cnt the byte
  // on mem_din_in belongs to address index r_cnt-1.
  assign w_cap_idx    = r_cnt - 3'd1;
  assign w_read_word  = r_buf | (32'(mem_din_in) << {w_cap_idx, 3'b000});
  assign w_read_last  = (r_state == S_READ)  && (r_cnt == r_nbytes);
  assign w_write_last = (r_state == S_WRITE) && (r_cnt == r_nbytes - 3'd1);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    mem_a_out    = '0;
    mem_dout_out = '0;
    mem_wr_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lsb_go)         w_state_nxt = lsb_ramctrl_rw_in ? S_WRITE : S_READ;
        else if (w_icache_go) w_state_nxt = S_READ;
      end
      S_READ: begin
        // The final READ cycle only captures; no address is driven then.
        if (r_cnt < r_nbytes) mem_a_out = r_addr + ADDRESS_WIDTH'(r_cnt);
        if (w_read_last)      w_state_nxt = S_DONE;
      end
      S_WRITE: begin
        mem_a_out    = r_addr + ADDRESS_WIDTH'(r_cnt);
        mem_dout_out = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        // Gated so a frozen controller never repeats a byte into RAM.
        mem_wr_out   = rdy_in;
        if (w_write_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state                      <= S_IDLE;
      r_addr                       <= '0;
      r_nbytes                     <= '0;
      r_cnt                        <= '0;
      r_is_lsb                     <= 1'b0;
      r_wdata                      <= '0;
      r_buf                        <= '0;
      ramctrl_icache_inst_rdy_out  <= 1'b0;
      ramctrl_icache_inst_inst_out <= '0;
      ramctrl_lsb_rdy_out          <= 1'b0;
      ramctrl_lsb_data_out         <= '0;
    end else if (rdy_in) begin
      r_state                     <= w_state_nxt;
      ramctrl_icache_inst_rdy_out <= 1'b0;
      ramctrl_lsb_rdy_out         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_buf <= '0;
          if (w_lsb_go) begin
            r_addr   <= lsb_ramctrl_addr_in;
            r_nbytes <= len_to_bytes(lsb_ramctrl_len_in);
            r_is_lsb <= 1'b1;
            r_wdata  <= lsb_ramctrl_data_in;
          end else if (w_icache_go) begin
            r_addr   <= icache_ramctrl_addr_in;
            r_nbytes <= 3'd4;
            r_is_lsb <= 1'b0;
            r_wdata  <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0) r_buf <= w_read_word;
          if (w_read_last) begin
            if (r_is_lsb) begin
              ramctrl_lsb_rdy_out  <= 1'b1;
              ramctrl_lsb_data_out <= w_read_word;
            end else begin
              ramctrl_icache_inst_rdy_out  <= 1'b1;
              ramctrl_icache_inst_inst_out <= w_read_word;
            end
          end
        end
        S_WRITE: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_write_last) ramctrl_lsb_rdy_out <= 1'b1;
        end
        S_DONE:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
